// File: rtl/wisc_branch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wisc_branch_pkg : condition codes, resolver states, flag bit indices |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package wisc_branch_pkg;

  typedef enum logic [2:0] {
    NEQ    = 3'b000,
    EQ     = 3'b001,
    GT     = 3'b010,
    LT     = 3'b011,
    GTE    = 3'b100,
    LTE    = 3'b101,
    OVFL   = 3'b110,
    UNCOND = 3'b111
  } cond_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    HELD       = 2'd2
  } state_t;

  // flags bus is packed {Z,V,N}
  localparam int Z_IDX = 2;
  localparam int V_IDX = 1;
  localparam int N_IDX = 0;

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cond_eval : combinational condition-code test on {Z,V,N}      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module branch_cond_eval
  import wisc_branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = flags[Z_IDX];
  assign w_v = flags[V_IDX];
  assign w_n = flags[N_IDX];

  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      NEQ:     taken = !w_z;
      EQ:      taken = w_z;
      GT:      taken = !w_z && !w_n;
      LT:      taken = w_n;
      GTE:     taken = w_z || !w_n;
      LTE:     taken = w_z || w_n;
      OVFL:    taken = w_v;
      UNCOND:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolver : decode-stage branch resolution, redirect, counters |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module branch_resolver
  import wisc_branch_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             IF_ID_valid,
  input  logic [PC_W-1:0]  IF_ID_PC_next,
  input  logic [1:0]       IF_ID_prediction,
  input  logic [PC_W-1:0]  IF_ID_predicted_target,
  input  logic             is_b,
  input  logic             is_br,
  input  logic [2:0]       cond,
  input  logic [8:0]       imm9,
  input  logic [PC_W-1:0]  reg_target,
  input  logic [2:0]       flags,
  input  logic             flags_pending,
  input  logic             stall_in,
  output logic             was_branch,
  output logic             actual_taken,
  output logic [PC_W-1:0]  actual_target,
  output logic             branch_mispredicted,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_IF_ID,
  output logic             stall_out,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] pred_taken_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] taken_count_q, taken_count_d;
  logic [CNT_W-1:0] pred_taken_count_q, pred_taken_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic            w_active;
  logic            w_is_branch;
  logic            w_br_here;
  logic            w_needs_flags;
  logic            w_taken;
  logic [PC_W-1:0] w_b_target;
  logic [PC_W-1:0] w_target;
  logic            w_mispred;
  logic            w_resolve;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + c_one : v;
  endfunction

  // Outputs are forced quiet while reset is asserted, not just after it.
  assign w_active      = enable & !rst;
  assign w_is_branch   = IF_ID_valid & (is_b | is_br);
  assign w_br_here     = w_is_branch & w_active;
  assign w_needs_flags = flags_pending & (cond_t'(cond) != UNCOND);

  branch_cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (w_taken)
  );

  assign w_b_target = IF_ID_PC_next + {{(PC_W-10){imm9[8]}}, imm9, 1'b0};
  assign w_target   = is_b ? w_b_target : reg_target;
  assign w_mispred  = (IF_ID_prediction[1] != w_taken) ||
                      (w_taken && IF_ID_prediction[1] && (IF_ID_predicted_target != w_target));

  always_comb begin
    state_d   = state_q;
    w_resolve = 1'b0;
    stall_out = 1'b0;
    if (w_active) begin
      case (state_q)
        IDLE: begin
          if (w_br_here) begin
            if (w_needs_flags) begin
              stall_out = 1'b1;
              state_d   = WAIT_FLAGS;
            end else begin
              w_resolve = 1'b1;
              state_d   = stall_in ? HELD : IDLE;
            end
          end
        end
        WAIT_FLAGS: begin
          if (!w_is_branch) begin
            state_d = IDLE;
          end else if (flags_pending) begin
            stall_out = 1'b1;
          end else begin
            w_resolve = 1'b1;
            state_d   = stall_in ? HELD : IDLE;
          end
        end
        // The instruction already resolved; stay silent until IF/ID moves on.
        HELD: begin
          if (!stall_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    branch_count_d     = sat_inc(branch_count_q, w_resolve);
    taken_count_d      = sat_inc(taken_count_q, w_resolve & w_taken);
    pred_taken_count_d = sat_inc(pred_taken_count_q, w_resolve & IF_ID_prediction[1]);
    mispredict_count_d = sat_inc(mispredict_count_q, w_resolve & w_mispred);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      branch_count_q     <= '0;
      taken_count_q      <= '0;
      pred_taken_count_q <= '0;
      mispredict_count_q <= '0;
    end else begin
      state_q            <= state_d;
      branch_count_q     <= branch_count_d;
      taken_count_q      <= taken_count_d;
      pred_taken_count_q <= pred_taken_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign was_branch          = w_resolve;
  assign actual_taken        = w_resolve & w_taken;
  assign actual_target       = w_resolve ? w_target : '0;
  assign branch_mispredicted = w_resolve & w_mispred;
  assign redirect_valid      = w_resolve & w_mispred;
  assign flush_IF_ID         = w_resolve & w_mispred;
  assign redirect_pc         = (w_resolve & w_mispred) ? (w_taken ? w_target : IF_ID_PC_next) : '0;

  assign branch_count     = branch_count_q;
  assign taken_count      = taken_count_q;
  assign pred_taken_count = pred_taken_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
Decode-stage branch resolution unit. It is the consumer end of the fetch-side dynamic branch predictor. It evaluates the real outcome of B/BR instructions in IF/ID and compares that outcome with the pipelined prediction and target. It then drives the predictor update bus (was_branch, actual_taken, actual_target, branch_mispredicted) and the fetch redirect/flush. It also stalls decode while condition flags are still in flight and keeps saturating performance counters.

Parameters:
CNT_W, 16, width of each performance counter
PC_W, 16, address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  global enable; low freezes state and counters, outputs deasserted
IF_ID_valid  in  1  IF/ID holds a valid instruction
IF_ID_PC_next  in  PC_W  PC+2 of the decode instruction
IF_ID_prediction  in  2  pipelined 2-bit counter; bit1 = predicted taken
IF_ID_predicted_target  in  PC_W  pipelined BTB target
is_b  in  1  instruction is B (PC-relative)
is_br  in  1  instruction is BR (register target)
cond  in  3  condition code
imm9  in  9  signed word offset for B
reg_target  in  PC_W  forwarded register value for BR
flags  in  3  {Z,V,N}
flags_pending  in  1  instruction in ID/EX will write flags this cycle
stall_in  in  1  downstream stall; IF/ID held
was_branch  out  1  resolution pulse to predictor
actual_taken  out  1  resolved direction
actual_target  out  PC_W  resolved target
branch_mispredicted  out  1  direction or target mismatch
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  PC_W  corrected fetch PC
flush_IF_ID  out  1  squash the wrongly fetched instruction
stall_out  out  1  hold PC and IF/ID while waiting on flags
branch_count, taken_count, pred_taken_count, mispredict_count  out  CNT_W each  performance counters

Behaviour:
- Reset: state IDLE; all counters 0; all 1-bit outputs 0; actual_target and redirect_pc 0. rst has priority over every other input, including during WAIT_FLAGS or HELD.
- br_here = IF_ID_valid & (is_b | is_br) & enable.
- Conditions (Z,V,N):
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: Z | N
  - 110 OVFL: V
  - 111 UNCOND: 1
- Target:
  - B: IF_ID_PC_next + (sign-extended imm9 << 1), modulo 2^PC_W (wrap allowed).
  - BR: reg_target.
- mispredicted = (IF_ID_prediction[1] != taken) | (taken & IF_ID_prediction[1] & IF_ID_predicted_target != target).
- FSM states: IDLE, WAIT_FLAGS, HELD.
  - IDLE, br_here & flags_pending & cond != 111: stall_out=1, no resolution outputs; go to WAIT_FLAGS.
  - IDLE, br_here otherwise: resolve this cycle (combinational outputs). If stall_in, go to HELD; else stay IDLE.
  - WAIT_FLAGS: stall_out=1 while flags_pending. When flags_pending=0, resolve that cycle, then go to HELD if stall_in, else IDLE. If IF_ID_valid drops (squashed), return to IDLE with no resolution.
  - HELD: no outputs asserted (single-shot); go to IDLE when stall_in=0.
- Resolve cycle:
  - Outputs: was_branch=1, actual_taken, actual_target, branch_mispredicted.
  - On mispredict: redirect_valid=1, flush_IF_ID=1, redirect_pc = taken ? target : IF_ID_PC_next.
  - Outside a resolve cycle, all these outputs are 0.
- Counters increment only in resolve cycles and saturate at all-ones:
  - branch_count always
  - taken_count if taken
  - pred_taken_count if IF_ID_prediction[1]
  - mispredict_count if mispredicted
- enable=0: no state change, counters hold, stall_out=0.
- Latency: resolution has zero cycles added beyond the flag wait. The predictor samples the update at the next posedge.

Decomposition:
- Package wisc_branch_pkg:
  - cond_t enum (NEQ..UNCOND)
  - resolver state_t enum
  - flag bit index constants Z_IDX, V_IDX, N_IDX
- Sub-module branch_cond_eval: combinational (cond, flags) -> taken.

Test Plan:
- After reset, B with cond=111, imm9=+4, PC_next=0x0004, prediction=00 -> was_branch=1, taken=1, target=0x000C, mispredicted=1, redirect_pc=0x000C, flush=1, mispredict_count=1.
- B with cond=001, Z=0, prediction=10 -> taken=0, mispredicted=1, redirect_pc=IF_ID_PC_next=0x0006; pred_taken_count increments, taken_count does not.
- BR with reg_target=0x0040, prediction=11, predicted_target=0x0020, cond=111 -> target mismatch: mispredicted=1, redirect_pc=0x0040.
- B with cond=010 and flags_pending high for 2 cycles -> stall_out=1 for 2 cycles; resolves on cycle 3 with the updated flags; exactly one was_branch pulse.
- Correct prediction (cond=111, prediction=11, target match) held under stall_in for 3 cycles -> one was_branch pulse, branch_count +1, no redirect.
- Preload counters near saturation (0xFFFF) and resolve again -> counter stays 0xFFFF; assert rst while in WAIT_FLAGS -> state IDLE, stall_out=0, counters 0.
